conv_window_mult: RTL and testbench
===================================

Name: conv_window_mult

Overview:
Upstream stage of the 3x3 convolution datapath. It buffers an incoming row-major pixel stream in a 3-row line buffer and multiplies each window column by the matching kernel column. Each window is emitted as three back-to-back beats (addr 0,1,2), with din1/din2/din3 carrying the top/middle/bottom row products. Its outputs connect directly to the 3x3 window-sum adder's din1..3, addr, enable and endSign_in.

Parameters:
IMG_W, 8, frame width in pixels (>=3)
IMG_H, 8, frame height in pixels (>=3)
PIX_W, 8, unsigned pixel width
WGT_W, 8, signed two's-complement weight width
OUT_W, 16, product width driven on din1..3

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
start  in  1  one-cycle pulse; begins a frame (honoured only in IDLE)
w_we  in  1  weight write strobe (honoured only in IDLE)
w_idx  in  4  weight index = row*3+col, 0..8; values 9..15 ignored
w_data  in  WGT_W  signed weight
pix_valid  in  1  pixel available
pix_data  in  PIX_W  pixel, row-major order
pix_ready  out  1  block accepts pixel this cycle
din1  out  OUT_W  top-row product
din2  out  OUT_W  middle-row product
din3  out  OUT_W  bottom-row product
addr  out  2  window column 0..2
enable  out  1  high on addr==2 beat; the window is complete after this edge
end_sign  out  1  high on addr==2 beat of the last window of the frame
busy  out  1  state != IDLE

Behaviour:
Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset clears all registered outputs (din1..3, addr, enable, end_sign) to 0, pix_ready=0, busy=0, state=IDLE, and all counters. Weights reset to 0; line-buffer contents are don't-care.
- States: IDLE, FILL, CONV, DONE.
- IDLE: w_we writes w[w_idx]. start moves the FSM to FILL and clears col, row and output-row counters.
- FILL: pix_ready=1. A pixel is accepted when pix_valid&&pix_ready and is written to the current write row at column col; col wraps at IMG_W-1.
  - On row completion: if fewer than 3 rows have been loaded, stay in FILL; otherwise go to CONV.
  - After the first fill, each FILL phase loads exactly one new row, overwriting the oldest row (3-row ring).
- CONV: pix_ready=0. For ox=0..IMG_W-3 and beat b=0..2, issue column ox+b, one beat per clock, with no gaps.
  - Registered output, 1 cycle after issue: addr=b; din1=top*w[b]; din2=mid*w[3+b]; din3=bot*w[6+b]; enable=(b==2).
  - end_sign=(b==2 && ox==IMG_W-3 && oy==IMG_H-3).
  - After the final beat of a row: if oy==IMG_H-3, go to DONE; otherwise oy++ and go to FILL.
- DONE: one cycle, then IDLE. A start seen in DONE is ignored.
- Idle beats (any cycle with no issue): din1..3=0, addr=0, enable=0, end_sign=0.
  - Downstream overwrites its slots every cycle; this is safe because every window rewrites all three slots consecutively before enable.
- Arithmetic: product = signed({1'b0,pix}) * signed(w), 17-bit full result, truncated to OUT_W=16 bits. The range fits exactly (min -32640 = 0x8080, max 32385). Overflow of the 9-term sum is a downstream matter.
- Per frame: (IMG_W-2)*(IMG_H-2) windows, 3 beats each, exactly one end_sign pulse.
- start while busy is ignored. w_we while busy is ignored and weights are unchanged.
- Reset mid-frame: outputs go to 0 immediately and the FSM enters IDLE. The next start runs a complete frame from pixel 0.

Optional Feature:
CONV_PERF_CNT_EN
- Defined: adds output ports perf_win (16 bits, count of enable beats since start) and perf_stall (16 bits, FILL cycles with pix_valid=0).
  - Both counters clear on start and hold value in IDLE.
  - Both saturate at 0xFFFF.
- Undefined: neither the ports nor the logic exist.

Decomposition:
- Package conv_pkg holds:
  - the state enum {IDLE, FILL, CONV, DONE};
  - KERNEL_TAPS=9 and KERNEL_DIM=3;
  - default PIX_W, WGT_W and OUT_W constants.
- Sub-module conv_line_buf implements the 3-row ring of IMG_W x PIX_W registers:
  - one write port;
  - combinational 3-row column read at a given column;
  - tracks which physical row is top, middle and bottom.

Test Plan:
1. Reset, then idle for 5 cycles -> din1..3=0, addr=0, enable=0, end_sign=0, pix_ready=0, busy=0.
2. All weights=1, 8x8 frame of pixels=1 -> 36 windows. Each beat has din1=din2=din3=1 with addr sequence 0,1,2. enable appears 36 times; end_sign appears once, on the 36th enable.
3. Identity kernel (w[4]=1, others 0), pixel=row*8+col -> at each addr=1 beat, din2=(oy+1)*8+ox+1; din1=din3=0 on every beat.
4. All weights=-128, all pixels=255 -> every din=16'h8080. All weights=127, pixels=255 -> every din=16'h7E81.
5. pix_valid toggling pseudo-randomly -> no pixel lost or duplicated, pix_ready=0 throughout CONV, and outputs match test 3's expected values.
6. rst_n asserted mid-CONV, then new weights and start -> outputs are 0 on reset, and the following frame is fully correct with exactly one end_sign. With CONV_PERF_CNT_EN defined, perf_win=36 at DONE.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared types and constants for the 3x3 convolution front end.
//   conv_state_e  : frame sequencer states (IDLE, FILL, CONV, DONE)
//   KERNEL_TAPS / KERNEL_DIM : kernel geometry (9 taps, 3x3)
//   DEF_PIX_W / DEF_WGT_W / DEF_OUT_W : default datapath widths
//   ring_add()    : modulo-3 add used to walk the 3-row line-buffer ring
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        CONV = 2'd2,
        DONE = 2'd3
    } conv_state_e;

    localparam int KERNEL_TAPS = 9;
    localparam int KERNEL_DIM  = 3;

    localparam int DEF_PIX_W = 8;
    localparam int DEF_WGT_W = 8;
    localparam int DEF_OUT_W = 16;

    // (base + off) mod 3, for base in 0..2 and off in 0..2
    function automatic logic [1:0] ring_add(input logic [1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= 32'd3) begin
            s = s - 32'd3;
        end
        return 2'(s);
    endfunction

endpackage

// File: rtl/conv_line_buf.sv
// conv_line_buf: 3-row ring of IMG_W x PIX_W registers.
//   clk, rst_n : clock, asynchronous active-low reset (ring pointer only)
//   clear      : restart the ring at physical row 0 (frame start)
//   we, wcol, wdata : pixel write into the current write row at column wcol;
//                     writing the last column advances the write row
//   rcol       : column to read
//   rd_pix[0..2] : combinational top / middle / bottom pixels at rcol
// Once three rows are loaded the write row is always the oldest row, so the
// write pointer itself names the top row and the next two ring slots give
// middle and bottom.
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int PIX_W = DEF_PIX_W,
    parameter int COL_W = $clog2(IMG_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             we,
    input  logic [COL_W-1:0] wcol,
    input  logic [PIX_W-1:0] wdata,
    input  logic [COL_W-1:0] rcol,
    output logic [PIX_W-1:0] rd_pix [KERNEL_DIM]
);

    logic [PIX_W-1:0] mem_q [KERNEL_DIM][IMG_W];
    logic [1:0]       wr_row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_row_q <= 2'd0;
        end else if (clear) begin
            wr_row_q <= 2'd0;
        end else if (we && (wcol == COL_W'(IMG_W - 1))) begin
            wr_row_q <= ring_add(wr_row_q, 1);
        end
    end

    // Pixel storage needs no reset: every row is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_row_q][wcol] <= wdata;
        end
    end

    for (genvar gi = 0; gi < KERNEL_DIM; gi++) begin : g_rd
        assign rd_pix[gi] = mem_q[ring_add(wr_row_q, gi)][rcol];
    end

endmodule

// File: rtl/conv_window_mult.sv
// conv_window_mult: line-buffers a row-major pixel stream and, for every 3x3
// window, emits three beats (addr 0,1,2) of per-row products window*kernel.
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : begin a frame (IDLE only)
//   w_we, w_idx, w_data: kernel weight write, idx=row*3+col (IDLE only)
//   pix_valid/pix_data/pix_ready : pixel stream handshake
//   din1..din3         : top/middle/bottom row products (registered)
//   addr, enable       : window column; enable marks the addr==2 beat
//   end_sign           : addr==2 beat of the frame's last window
//   busy               : sequencer not in IDLE
// Optional macro CONV_PERF_CNT_EN adds perf_win (enable beats since start)
// and perf_stall (FILL cycles without pix_valid), both saturating.
module conv_window_mult
    import conv_pkg::*;
#(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int PIX_W = DEF_PIX_W,
    parameter int WGT_W = DEF_WGT_W,
    parameter int OUT_W = DEF_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    w_we,
    input  logic [3:0]              w_idx,
    input  logic signed [WGT_W-1:0] w_data,
    input  logic                    pix_valid,
    input  logic [PIX_W-1:0]        pix_data,
    output logic                    pix_ready,
    output logic [OUT_W-1:0]        din1,
    output logic [OUT_W-1:0]        din2,
    output logic [OUT_W-1:0]        din3,
    output logic [1:0]              addr,
    output logic                    enable,
    output logic                    end_sign,
    output logic                    busy
`ifdef CONV_PERF_CNT_EN
    ,
    output logic [15:0]             perf_win,
    output logic [15:0]             perf_stall
`endif
);

    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = $clog2(IMG_H);
    localparam int PROD_W = PIX_W + WGT_W + 1;

    conv_state_e state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;   // write column in FILL
    logic [1:0]       rows_q, rows_d; // rows loaded, saturates at 3
    logic [COL_W-1:0] ox_q, ox_d;
    logic [ROW_W-1:0] oy_q, oy_d;
    logic [1:0]       b_q, b_d;

    logic issue, buf_clear, buf_we;
    logic win_last, frame_last;

    logic signed [WGT_W-1:0] w_q [KERNEL_TAPS];
    logic [PIX_W-1:0]        rd_pix [KERNEL_DIM];
    logic [OUT_W-1:0]        prod_trunc [KERNEL_DIM];

    logic [OUT_W-1:0] din_q [KERNEL_DIM];
    logic [1:0]       addr_q;
    logic             enable_q, end_q;

    assign win_last   = (b_q == 2'd2) && (ox_q == COL_W'(IMG_W - 3));
    assign frame_last = win_last && (oy_q == ROW_W'(IMG_H - 3));

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        rows_d    = rows_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        b_d       = b_q;
        pix_ready = 1'b0;
        issue     = 1'b0;
        buf_clear = 1'b0;
        buf_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = FILL;
                    col_d     = '0;
                    rows_d    = 2'd0;
                    ox_d      = '0;
                    oy_d      = '0;
                    b_d       = 2'd0;
                    buf_clear = 1'b1;
                end
            end
            FILL: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    buf_we = 1'b1;
                    if (col_q == COL_W'(IMG_W - 1)) begin
                        col_d = '0;
                        // First visit needs three rows; afterwards one row refills the ring.
                        if (rows_q < 2'd2) begin
                            rows_d = rows_q + 2'd1;
                        end else begin
                            rows_d  = 2'd3;
                            state_d = CONV;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            CONV: begin
                issue = 1'b1;
                if (b_q == 2'd2) begin
                    b_d = 2'd0;
                    if (win_last) begin
                        ox_d = '0;
                        if (frame_last) begin
                            state_d = DONE;
                        end else begin
                            oy_d    = oy_q + ROW_W'(1);
                            state_d = FILL;
                        end
                    end else begin
                        ox_d = ox_q + COL_W'(1);
                    end
                end else begin
                    b_d = b_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            rows_q  <= 2'd0;
            ox_q    <= '0;
            oy_q    <= '0;
            b_q     <= 2'd0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            rows_q  <= rows_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            b_q     <= b_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KERNEL_TAPS; i++) begin
                w_q[i] <= '0;
            end
        end else if ((state_q == IDLE) && w_we && (w_idx < 4'(KERNEL_TAPS))) begin
            w_q[w_idx] <= w_data;
        end
    end

    conv_line_buf #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W),
        .COL_W (COL_W)
    ) u_line_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (buf_clear),
        .we     (buf_we),
        .wcol   (col_q),
        .wdata  (pix_data),
        .rcol   (ox_q + COL_W'(b_q)),
        .rd_pix (rd_pix)
    );

    // Pixels are unsigned: a zero MSB makes them non-negative signed operands,
    // so the product is exact in PROD_W bits before truncation to OUT_W.
    for (genvar gi = 0; gi < KERNEL_DIM; gi++) begin : g_row
        logic signed [WGT_W-1:0]  w_sel;
        logic signed [PROD_W-1:0] prod;
        assign w_sel          = w_q[KERNEL_DIM * gi + int'(b_q)];
        assign prod           = $signed({1'b0, rd_pix[gi]}) * w_sel;
        assign prod_trunc[gi] = OUT_W'(prod);
    end

    // Non-issue cycles drive zeros so downstream slots never see stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KERNEL_DIM; i++) begin
                din_q[i] <= '0;
            end
            addr_q   <= 2'd0;
            enable_q <= 1'b0;
            end_q    <= 1'b0;
        end else begin
            for (int i = 0; i < KERNEL_DIM; i++) begin
                din_q[i] <= issue ? prod_trunc[i] : '0;
            end
            addr_q   <= issue ? b_q : 2'd0;
            enable_q <= issue && (b_q == 2'd2);
            end_q    <= issue && frame_last;
        end
    end

    assign din1     = din_q[0];
    assign din2     = din_q[1];
    assign din3     = din_q[2];
    assign addr     = addr_q;
    assign enable   = enable_q;
    assign end_sign = end_q;
    assign busy     = (state_q != IDLE);

`ifdef CONV_PERF_CNT_EN
    logic [15:0] perf_win_q, perf_stall_q;

    // Counted at issue so the total is visible on the same edge as enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_win_q   <= '0;
            perf_stall_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            perf_win_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            if (issue && (b_q == 2'd2) && (perf_win_q != 16'hFFFF)) begin
                perf_win_q <= perf_win_q + 16'd1;
            end
            if ((state_q == FILL) && !pix_valid && (perf_stall_q != 16'hFFFF)) begin
                perf_stall_q <= perf_stall_q + 16'd1;
            end
        end
    end

    assign perf_win   = perf_win_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_conv_window_mult.sv
// Directed bench for conv_window_mult (8x8 frame, 36 windows per frame).
module tb_conv_window_mult;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              w_we;
    logic [3:0]        w_idx;
    logic signed [7:0] w_data;
    logic              pix_valid;
    logic [7:0]        pix_data;
    logic              pix_ready;
    logic [15:0]       din1, din2, din3;
    logic [1:0]        addr;
    logic              enable;
    logic              end_sign;
    logic              busy;
`ifdef CONV_PERF_CNT_EN
    logic [15:0]       perf_win, perf_stall;
`endif

    int n_checks = 0;
    int n_errors = 0;

    int                img [64];
    logic signed [7:0] wm  [9];

    always #5 clk = ~clk;

    conv_window_mult #(
        .IMG_W (8),
        .IMG_H (8),
        .PIX_W (8),
        .WGT_W (8),
        .OUT_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .w_we      (w_we),
        .w_idx     (w_idx),
        .w_data    (w_data),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .din1      (din1),
        .din2      (din2),
        .din3      (din3),
        .addr      (addr),
        .enable    (enable),
        .end_sign  (end_sign),
        .busy      (busy)
`ifdef CONV_PERF_CNT_EN
        ,
        .perf_win   (perf_win),
        .perf_stall (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] expp(input int p, input logic signed [7:0] w);
        int r;
        r = p * int'(w);
        return r[15:0];
    endfunction

    task automatic w_write(input int idx, input logic signed [7:0] d);
        @(negedge clk);
        w_we   = 1'b1;
        w_idx  = 4'(idx);
        w_data = d;
        @(negedge clk);
        w_we   = 1'b0;
        if (idx < 9) wm[idx] = d;
    endtask

    task automatic load_all(input logic signed [7:0] d);
        for (int i = 0; i < 9; i++) w_write(i, d);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_din1"}, 32'(din1), 32'h0);
        chk({tag, "_din2"}, 32'(din2), 32'h0);
        chk({tag, "_din3"}, 32'(din3), 32'h0);
        chk({tag, "_addr"}, 32'(addr), 32'h0);
        chk({tag, "_en"},   32'(enable), 32'h0);
        chk({tag, "_end"},  32'(end_sign), 32'h0);
        chk({tag, "_rdy"},  32'(pix_ready), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    // Runs one frame from start; checks every completed window against the
    // bench model. abort_wins>0 returns right after that many windows.
    task automatic run_frame(input string tag, input bit rnd, input int abort_wins);
        int          idx, wins, ends, stalls, k, oy, ox;
        bit          pv, acc, pr_now, done;
        logic [15:0] hd [3][3];
        logic [1:0]  ha [3];
        logic        hp [3];
        idx = 0; wins = 0; ends = 0; stalls = 0; done = 1'b0;
        for (int s = 0; s < 3; s++) begin
            ha[s] = 2'd0; hp[s] = 1'b1;
            for (int r = 0; r < 3; r++) hd[s][r] = 16'h0;
        end
        @(negedge clk);
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            pv        = (idx < 64) && (!rnd || ($urandom_range(0, 1) == 1));
            pix_valid = pv;
            pix_data  = (idx < 64) ? 8'(img[idx]) : 8'h0;
            start     = (cyc == 0) || (cyc == 12);   // second pulse lands while busy
            w_we      = (cyc == 5);                  // weight write while busy
            w_idx     = 4'd4;
            w_data    = 8'sh55;
            pr_now    = pix_ready;
            acc       = pv && pix_ready;
            if (pix_ready && !pv) stalls++;
            @(negedge clk);
            if (acc) idx++;
            for (int s = 0; s < 2; s++) begin
                ha[s] = ha[s+1]; hp[s] = hp[s+1];
                for (int r = 0; r < 3; r++) hd[s][r] = hd[s+1][r];
            end
            ha[2] = addr; hp[2] = pr_now;
            hd[2][0] = din1; hd[2][1] = din2; hd[2][2] = din3;
            if (enable) begin
                k  = wins;
                oy = k / 6;
                ox = k % 6;
                for (int b = 0; b < 3; b++) begin
                    chk($sformatf("%s_w%0d_addr%0d", tag, k, b), 32'(ha[b]), 32'(b));
                    chk($sformatf("%s_w%0d_rdy%0d", tag, k, b), 32'(hp[b]), 32'h0);
                    for (int r = 0; r < 3; r++)
                        chk($sformatf("%s_w%0d_b%0d_din%0d", tag, k, b, r + 1), 32'(hd[b][r]),
                            32'(expp(img[(oy + r) * 8 + ox + b], wm[r * 3 + b])));
                end
                wins++;
                if (abort_wins > 0 && wins == abort_wins) begin
                    pix_valid = 1'b0; start = 1'b0; w_we = 1'b0;
                    return;
                end
            end
            if (end_sign) begin
                ends++;
                chk({tag, "_end_on_en"}, 32'(enable), 32'h1);
                chk({tag, "_end_at_win"}, 32'(wins), 32'd36);
`ifdef CONV_PERF_CNT_EN
                chk({tag, "_perf_win"}, 32'(perf_win), 32'd36);
                chk({tag, "_perf_stall"}, 32'(perf_stall), 32'(stalls));
`endif
            end
            if (ends > 0 && !busy) done = 1'b1;
        end
        pix_valid = 1'b0; start = 1'b0; w_we = 1'b0;
        chk({tag, "_finished"}, 32'(done), 32'h1);
        chk({tag, "_windows"}, 32'(wins), 32'd36);
        chk({tag, "_end_cnt"}, 32'(ends), 32'd1);
        chk({tag, "_pixels"}, 32'(idx), 32'd64);
        @(negedge clk);
        check_idle_outputs({tag, "_after"});
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; w_we = 1'b0; w_idx = 4'd0; w_data = 8'sh0;
        pix_valid = 1'b0; pix_data = 8'h0;
        for (int i = 0; i < 9; i++) wm[i] = 8'sh0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: reset / idle
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_idle_outputs($sformatf("idle%0d", c));
        end

        // 2: all-ones
        load_all(8'sd1);
        for (int i = 0; i < 64; i++) img[i] = 1;
        run_frame("ones", 1'b0, 0);

        // 3: identity kernel, ramp image; out-of-range index must be ignored
        load_all(8'sd0);
        w_write(4, 8'sd1);
        w_write(12, 8'sd99);
        for (int i = 0; i < 64; i++) img[i] = i;
        run_frame("ident", 1'b0, 0);

        // 4: extreme products
        load_all(-8'sd128);
        for (int i = 0; i < 64; i++) img[i] = 255;
        run_frame("neg", 1'b0, 0);
        load_all(8'sd127);
        run_frame("pos", 1'b0, 0);

        // 5: identity kernel with bursty pixel valid
        load_all(8'sd0);
        w_write(4, 8'sd1);
        for (int i = 0; i < 64; i++) img[i] = i;
        run_frame("bursty", 1'b1, 0);

        // 6: reset in the middle of CONV, then a fresh frame
        load_all(8'sd3);
        run_frame("abort", 1'b0, 10);
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("rst");
        for (int i = 0; i < 9; i++) wm[i] = 8'sh0;
        @(negedge clk);
        rst_n = 1'b1;
        w_write(0, 8'sd1);  w_write(1, -8'sd2); w_write(2, 8'sd3);
        w_write(3, -8'sd4); w_write(4, 8'sd5);  w_write(5, -8'sd6);
        w_write(6, 8'sd7);  w_write(7, -8'sd8); w_write(8, 8'sd9);
        for (int i = 0; i < 64; i++) img[i] = (i * 7 + 3) % 256;
        run_frame("post_rst", 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
